// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for a UART: stores {err, data} per received byte,
// show-ahead head output, sticky overflow flag and fill-level watermark.
module uart_rx_fifo #(
    parameter int DEPTH     = 8,
    parameter int WATERMARK = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_done,
    input  logic                     rx_err,
    input  logic                     pop,
    input  logic                     flush,
    input  logic                     ovf_clr,
    output logic [7:0]               rd_data,
    output logic                     rd_err,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     wm_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_WM   = CW'(WATERMARK);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [8:0]    mem_q [DEPTH];
    logic [8:0]    head;

    logic push_req;
    logic pop_ok;
    logic push_ok;
    logic drop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_FULL);
    assign count  = count_q;
    assign wm_irq = (count_q >= CNT_WM);
    assign overflow = ovf_q;

    // Show-ahead: head word is read straight from storage, masked when empty.
    assign head    = mem_q[rd_ptr_q];
    assign rd_data = empty ? 8'h00 : head[7:0];
    assign rd_err  = empty ? 1'b0 : head[8];

    always_comb begin
        push_req = rx_done && !flush;
        pop_ok   = pop && !empty && !flush;
        push_ok  = push_req && (!full || pop_ok);
        drop     = push_req && full && !pop_ok;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // A new drop wins over a coincident clear so no loss goes unreported.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[wr_ptr_q] <= {rx_err, rx_data};
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table plus multi-cycle sequences.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_err;
    logic       pop;
    logic       flush;
    logic       ovf_clr;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overflow;
    logic       wm_irq;

    int checks = 0;
    int failures = 0;

    uart_rx_fifo #(.DEPTH(8), .WATERMARK(4)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
        .rx_err(rx_err), .pop(pop), .flush(flush), .ovf_clr(ovf_clr),
        .rd_data(rd_data), .rd_err(rd_err), .empty(empty), .full(full),
        .count(count), .overflow(overflow), .wm_irq(wm_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       done;
        logic [7:0] d;
        logic       err;
        logic       pp;
        logic       fl;
        logic       clr;
        logic       e;
        logic       f;
        int         c;
        logic [7:0] rd;
        logic       re;
        logic       ov;
        logic       wm;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic done, input logic [7:0] d,
                         input logic err, input logic pp, input logic fl,
                         input logic clr);
        reset = rst; rx_done = done; rx_data = d; rx_err = err;
        pop = pp; flush = fl; ovf_clr = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive(0, 0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic chk_all(input string n, input logic e, input logic f,
                           input int c, input logic [7:0] rd, input logic re,
                           input logic ov, input logic wm);
        chk({n, ".empty"}, int'(empty), int'(e));
        chk({n, ".full"}, int'(full), int'(f));
        chk({n, ".count"}, int'(count), c);
        chk({n, ".rd_data"}, int'(rd_data), int'(rd));
        chk({n, ".rd_err"}, int'(rd_err), int'(re));
        chk({n, ".overflow"}, int'(overflow), int'(ov));
        chk({n, ".wm_irq"}, int'(wm_irq), int'(wm));
    endtask

    task automatic do_reset();
        drive(1, 0, 8'h00, 0, 0, 0, 0);
        tick();
    endtask

    task automatic push_byte(input logic [7:0] d);
        drive(0, 1, d, 0, 0, 0, 0);
        tick();
    endtask

    task automatic pop_one();
        drive(0, 0, 8'h00, 0, 1, 0, 0);
        tick();
    endtask

    logic [7:0] q [$];
    logic [7:0] b;
    logic       do_pop;

    initial begin
        drive(1, 0, 8'h00, 0, 0, 0, 0);
        //          name       rst done data  err pop fl clr  e f c rd    re ov wm
        tbl[0]  = '{"reset",    1, 1, 8'h99, 1, 1, 0, 0,  1,0,0,8'h00,0,0,0};
        tbl[1]  = '{"push41",   0, 1, 8'h41, 0, 0, 0, 0,  0,0,1,8'h41,0,0,0};
        tbl[2]  = '{"pop41",    0, 0, 8'h00, 0, 1, 0, 0,  1,0,0,8'h00,0,0,0};
        tbl[3]  = '{"popempty", 0, 0, 8'h00, 0, 1, 0, 0,  1,0,0,8'h00,0,0,0};
        tbl[4]  = '{"push55e",  0, 1, 8'h55, 1, 0, 0, 0,  0,0,1,8'h55,1,0,0};
        tbl[5]  = '{"push10",   0, 1, 8'h10, 0, 0, 0, 0,  0,0,2,8'h55,1,0,0};
        tbl[6]  = '{"push11",   0, 1, 8'h11, 0, 0, 0, 0,  0,0,3,8'h55,1,0,0};
        tbl[7]  = '{"push12wm", 0, 1, 8'h12, 0, 0, 0, 0,  0,0,4,8'h55,1,0,1};
        tbl[8]  = '{"popwm",    0, 0, 8'h00, 0, 1, 0, 0,  0,0,3,8'h10,0,0,0};
        tbl[9]  = '{"pushpop",  0, 1, 8'h13, 0, 1, 0, 0,  0,0,3,8'h11,0,0,0};
        tbl[10] = '{"idle",     0, 0, 8'h00, 0, 0, 0, 0,  0,0,3,8'h11,0,0,0};
        tbl[11] = '{"flushpop", 0, 1, 8'h77, 0, 1, 1, 0,  1,0,0,8'h00,0,0,0};
        tbl[12] = '{"emptypp",  0, 1, 8'h66, 0, 1, 0, 0,  0,0,1,8'h66,0,0,0};
        tbl[13] = '{"pop66",    0, 0, 8'h00, 0, 1, 0, 0,  1,0,0,8'h00,0,0,0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rst, tbl[i].done, tbl[i].d, tbl[i].err,
                  tbl[i].pp, tbl[i].fl, tbl[i].clr);
            tick();
            chk_all(tbl[i].name, tbl[i].e, tbl[i].f, tbl[i].c,
                    tbl[i].rd, tbl[i].re, tbl[i].ov, tbl[i].wm);
        end

        // Nine pushes into eight slots, then drain in order.
        do_reset();
        for (int i = 0; i < 8; i++) push_byte(8'(i));
        chk_all("fill8", 0, 1, 8, 8'h00, 0, 0, 1);
        push_byte(8'h08);
        chk_all("drop9", 0, 1, 8, 8'h00, 0, 1, 1);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", int'(rd_data), i);
            pop_one();
        end
        chk_all("drained", 1, 0, 0, 8'h00, 0, 1, 0);
        drive(0, 0, 8'h00, 0, 0, 0, 1);
        tick();
        chk("ovf_clr", int'(overflow), 0);

        // Full with simultaneous push and pop: no drop, 0xAA arrives last.
        do_reset();
        for (int i = 0; i < 8; i++) push_byte(8'(i + 1));
        drive(0, 1, 8'hAA, 0, 1, 0, 0);
        tick();
        chk_all("fullpp", 0, 1, 8, 8'h02, 0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            chk("fullpp_order", int'(rd_data), i + 2);
            pop_one();
        end
        chk("fullpp_last", int'(rd_data), 8'hAA);
        pop_one();
        chk("fullpp_empty", int'(empty), 1);

        // Drop coinciding with ovf_clr keeps overflow set.
        do_reset();
        for (int i = 0; i < 8; i++) push_byte(8'h30);
        drive(0, 1, 8'h31, 0, 0, 0, 1);
        tick();
        chk("clr_vs_drop", int'(overflow), 1);

        // Flush with five entries and a same-cycle push; overflow sticks.
        pop_one(); pop_one(); pop_one();
        chk("pre_flush_cnt", int'(count), 5);
        drive(0, 1, 8'h77, 0, 0, 1, 0);
        tick();
        chk_all("flush", 1, 0, 0, 8'h00, 0, 1, 0);
        push_byte(8'h01);
        chk_all("post_flush", 0, 0, 1, 8'h01, 0, 1, 0);

        // Interleaved traffic across pointer wrap against a queue model.
        do_reset();
        q.delete();
        for (int i = 0; i < 20; i++) begin
            b = 8'(i * 7 + 3);
            do_pop = (q.size() >= 3);
            if (do_pop) chk("wrap_head", int'(rd_data), int'(q[0]));
            drive(0, 1, b, 0, do_pop, 0, 0);
            tick();
            if (do_pop) void'(q.pop_front());
            q.push_back(b);
            chk("wrap_count", int'(count), q.size());
        end
        while (q.size() > 0) begin
            chk("wrap_drain", int'(rd_data), int'(q[0]));
            pop_one();
            void'(q.pop_front());
        end
        chk("wrap_empty", int'(empty), 1);

        // Reset mid-stream, with other inputs active during reset.
        for (int i = 0; i < 5; i++) push_byte(8'hE0);
        drive(1, 1, 8'hEE, 1, 1, 0, 0);
        tick();
        chk_all("mid_reset", 1, 0, 0, 8'h00, 0, 0, 0);
        push_byte(8'h9C);
        chk_all("after_reset", 0, 0, 1, 8'h9C, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of entries; power of two, 2..256.
REQ-002 SHALL have parameter WATERMARK, default 4: fill level (1..DEPTH) that asserts wm_irq.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  8  received byte from the UART receiver.
REQ-006 SHALL have port rx_done  input  1  one-cycle pulse; rx_data/rx_err valid this cycle.
REQ-007 SHALL have port rx_err  input  1  framing error flag for the byte qualified by rx_done.
REQ-008 SHALL have port pop  input  1  consumer removes the head entry.
REQ-009 SHALL have port flush  input  1  discard all entries.
REQ-010 SHALL have port ovf_clr  input  1  clear sticky overflow.
REQ-011 SHALL have port rd_data  output  8  head byte (show-ahead).
REQ-012 SHALL have port rd_err  output  1  error bit stored with the head byte.
REQ-013 SHALL have port empty  output  1  no entries held.
REQ-014 SHALL have port full  output  1  DEPTH entries held.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  entries held, 0..DEPTH.
REQ-016 SHALL have port overflow  output  1  sticky: a byte was dropped.
REQ-017 SHALL have port wm_irq  output  1  count >= WATERMARK.

Function
REQ-018 SHALL store one 9-bit entry {rx_err, rx_data} per push; push = rx_done && !flush.
REQ-019 SHALL accept a push when not full, or when full and an accepted pop occurs the same cycle.
REQ-020 SHALL drop the byte and set overflow when a push arrives while full with no accepted pop.
REQ-021 SHALL accept a pop only when !empty && !flush; a pop while empty SHALL be ignored with no state change.
REQ-022 SHALL make a pushed entry visible the cycle after rx_done: empty deasserts, count increments, rd_data/rd_err valid.
REQ-023 SHALL, on an accepted pop, present the next entry on rd_data/rd_err in the following cycle.
REQ-024 SHALL drive rd_data=0 and rd_err=0 whenever empty=1.
REQ-025 SHALL derive rd_data/rd_err directly from the head storage word, with no extra register stage.
REQ-026 SHALL, on simultaneous accepted push and pop, leave count unchanged and advance both pointers.
REQ-027 SHALL, on push while empty together with pop, ignore the pop and accept the push (count 0->1).
REQ-028 SHALL wrap read and write pointers modulo DEPTH.
REQ-029 SHALL maintain count as a register; empty = (count==0); full = (count==DEPTH).
REQ-030 SHALL give flush highest priority: count, pointers to 0 next cycle; same-cycle push and pop discarded; overflow unaffected.
REQ-031 SHALL clear overflow on ovf_clr; if ovf_clr coincides with a new drop, overflow SHALL remain 1.
REQ-032 SHALL drive wm_irq combinationally from the count register (count >= WATERMARK).
REQ-033 SHALL never alter a stored entry except by overwrite on push into a free slot.

Reset
REQ-034 SHALL, while reset=1 at a clock edge, set count=0, both pointers=0, overflow=0, ignoring all other inputs.
REQ-035 SHALL present after reset: empty=1, full=0, count=0, rd_data=0, rd_err=0, overflow=0, wm_irq=0.
REQ-036 SHALL not require storage array contents to be reset.
REQ-037 SHALL abandon any in-progress fill on reset mid-operation; the first push after reset lands in entry 0.

Verification
REQ-038 SHALL verify: rx_done with rx_data=0x41, rx_err=0 -> next cycle empty=0, count=1, rd_data=0x41; pop -> next cycle empty=1, rd_data=0.
REQ-039 SHALL verify: 9 pushes 0x00..0x08 with DEPTH=8, no pops -> full=1, count=8, overflow=1; 8 pops read 0x00..0x07 in order.
REQ-040 SHALL verify: full FIFO with push 0xAA and pop in same cycle -> count stays 8, overflow stays 0, 0xAA read last.
REQ-041 SHALL verify: push 0x55 with rx_err=1 -> rd_err=1 with rd_data=0x55; 4 total pushes -> wm_irq=1; one pop -> wm_irq=0.
REQ-042 SHALL verify: 5 entries, flush asserted with push 0x77 -> next cycle count=0, empty=1; 0x77 never read; overflow unchanged.
REQ-043 SHALL verify: 20 pushes and pops interleaved across pointer wrap -> output order matches input order; reset mid-stream -> state per REQ-035.
